// File: rtl/reg_bank_spill_pkg.sv
// Shared types and constants for the register bank spill/fill sequencer.
// Holds the state encoding, special register numbers and transfer modes.
package reg_bank_spill_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAVE,
      S_RD_REQ,
      S_RD_WR,
      S_DONE
   } state_e;

   localparam logic [2:0] REG_ZERO = 3'd0;
   localparam logic [2:0] REG_PC   = 3'd6;

   localparam logic MODE_SAVE    = 1'b0;
   localparam logic MODE_RESTORE = 1'b1;

endpackage

// File: rtl/reg_bank_spill.sv
// Context save/restore sequencer: streams r1..r7 of one bank to memory
// or loads them back, routing the PC slot through the PC write port.
module reg_bank_spill
   import reg_bank_spill_pkg::*;
#(
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = 7,
   parameter int PC_REG    = 6,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic              bank,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              rf_bank,
   output logic [2:0]        rf_read_num,
   input  logic [15:0]       rf_read_data,
   output logic [2:0]        rf_write_num,
   output logic [15:0]       rf_write_data,
   output logic              rf_write_en,
   output logic [15:0]       rf_pc_write_data,
   output logic              rf_pc_write_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ready
);

   localparam logic [2:0] FIRST = 3'(FIRST_REG);
   localparam logic [2:0] LAST  = 3'(LAST_REG);
   localparam logic [2:0] PC    = 3'(PC_REG);

   state_e            state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic              bank_q, bank_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [15:0]       hold_q, hold_d;

   logic [2:0]        off;
   logic [ADDR_W-1:0] addr;
   logic              last;

   assign off  = idx_q - FIRST;
   // Wraps modulo 2^ADDR_W by construction of the adder width.
   assign addr = base_q + {{(ADDR_W-3){1'b0}}, off};
   assign last = (idx_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= FIRST;
         bank_q  <= 1'b0;
         base_q  <= '0;
         hold_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bank_q  <= bank_d;
         base_q  <= base_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      bank_d           = bank_q;
      base_d           = base_q;
      hold_d           = hold_q;
      busy             = 1'b0;
      done             = 1'b0;
      rf_bank          = 1'b0;
      rf_read_num      = REG_ZERO;
      rf_write_num     = REG_ZERO;
      rf_write_data    = 16'h0000;
      rf_write_en      = 1'b0;
      rf_pc_write_data = 16'h0000;
      rf_pc_write_en   = 1'b0;
      mem_addr         = '0;
      mem_wdata        = 16'h0000;
      mem_we           = 1'b0;
      mem_re           = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               bank_d  = bank;
               base_d  = base_addr;
               idx_d   = FIRST;
               state_d = (mode == MODE_RESTORE) ? S_RD_REQ : S_SAVE;
            end
         end
         S_SAVE: begin
            busy        = 1'b1;
            rf_bank     = bank_q;
            rf_read_num = idx_q;
            mem_addr    = addr;
            mem_wdata   = rf_read_data;
            mem_we      = 1'b1;
            if (mem_ready) begin
               if (last) state_d = S_DONE;
               else      idx_d   = idx_q + 3'd1;
            end
         end
         S_RD_REQ: begin
            busy     = 1'b1;
            rf_bank  = bank_q;
            mem_addr = addr;
            mem_re   = 1'b1;
            if (mem_ready) begin
               hold_d  = mem_rdata;
               state_d = S_RD_WR;
            end
         end
         S_RD_WR: begin
            busy    = 1'b1;
            rf_bank = bank_q;
            // The PC slot bypasses the general port so condition bits
            // end up reflecting the last general register restored.
            if (idx_q == PC) begin
               rf_pc_write_en   = 1'b1;
               rf_pc_write_data = hold_q;
            end else begin
               rf_write_en   = 1'b1;
               rf_write_num  = idx_q;
               rf_write_data = hold_q;
            end
            if (last) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = S_RD_REQ;
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            rf_bank = bank_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_bank_spill.sv
// Directed bench for reg_bank_spill with register-file and memory models.
// Expected values are hand-computed constants per scenario.
module tb_reg_bank_spill;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic        bank;
   logic [15:0] base_addr;
   logic        busy;
   logic        done;
   logic        rf_bank;
   logic [2:0]  rf_read_num;
   logic [15:0] rf_read_data;
   logic [2:0]  rf_write_num;
   logic [15:0] rf_write_data;
   logic        rf_write_en;
   logic [15:0] rf_pc_write_data;
   logic        rf_pc_write_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [15:0] mem_rdata;
   logic        mem_ready;

   reg_bank_spill dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .mode             (mode),
      .bank             (bank),
      .base_addr        (base_addr),
      .busy             (busy),
      .done             (done),
      .rf_bank          (rf_bank),
      .rf_read_num      (rf_read_num),
      .rf_read_data     (rf_read_data),
      .rf_write_num     (rf_write_num),
      .rf_write_data    (rf_write_data),
      .rf_write_en      (rf_write_en),
      .rf_pc_write_data (rf_pc_write_data),
      .rf_pc_write_en   (rf_pc_write_en),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_we           (mem_we),
      .mem_re           (mem_re),
      .mem_rdata        (mem_rdata),
      .mem_ready        (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] rfm [0:1][0:7];
   logic [15:0] mem [0:65535];
   logic [15:0] wla [0:255];
   logic [15:0] wld [0:255];
   int wr_n = 0, rd_n = 0, gw_n = 0, gw6_n = 0, pw_n = 0;
   int both_w = 0, both_r = 0, done_n = 0, unstable = 0;
   int wcnt = 0, wait_cfg = 0;
   logic        prev_wait = 1'b0;
   logic [15:0] pa = 16'h0, pd = 16'h0;
   logic        ld_en, ld_rf, ld_bk;
   logic [15:0] ld_addr, ld_data;

   assign rf_read_data = rfm[rf_bank][rf_read_num];
   assign mem_rdata    = mem[mem_addr];
   assign mem_ready    = (mem_we || mem_re) && (wcnt >= wait_cfg);

   always @(posedge clk) begin
      if ((mem_we || mem_re) && !mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   always @(negedge clk) begin
      if (ld_en) begin
         if (ld_rf) rfm[ld_bk][ld_addr[2:0]] <= ld_data;
         else       mem[ld_addr] <= ld_data;
      end
      if (!rst_n) begin
         prev_wait <= 1'b0;
      end else begin
         if (mem_we && mem_ready) begin
            mem[mem_addr] <= mem_wdata;
            wla[wr_n[7:0]] <= mem_addr;
            wld[wr_n[7:0]] <= mem_wdata;
            wr_n <= wr_n + 1;
         end
         if (mem_re && mem_ready) rd_n <= rd_n + 1;
         if (rf_write_en) begin
            rfm[rf_bank][rf_write_num] <= rf_write_data;
            gw_n <= gw_n + 1;
            if (rf_write_num == 3'd6) gw6_n <= gw6_n + 1;
         end
         if (rf_pc_write_en) begin
            rfm[rf_bank][6] <= rf_pc_write_data;
            pw_n <= pw_n + 1;
         end
         if (rf_write_en && rf_pc_write_en) both_w <= both_w + 1;
         if (mem_we && mem_re) both_r <= both_r + 1;
         if (done) done_n <= done_n + 1;
         if (prev_wait && !(mem_we && mem_addr == pa && mem_wdata == pd))
            unstable <= unstable + 1;
         prev_wait <= mem_we && !mem_ready;
         pa <= mem_addr;
         pd <= mem_wdata;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic any_out();
      return |{busy, done, rf_bank, rf_read_num, rf_write_num,
               rf_write_data, rf_write_en, rf_pc_write_data,
               rf_pc_write_en, mem_addr, mem_wdata, mem_we, mem_re};
   endfunction

   task automatic ld(input logic isrf, input logic bk,
                     input logic [15:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_rf = isrf; ld_bk = bk; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic run(input logic md, input logic bk,
                      input logic [15:0] base, input int poke,
                      input int abort, output int dcyc);
      int n;
      mode = md; bank = bk; base_addr = base; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mode = ~md; bank = ~bk; base_addr = 16'hDEAD;
      n = 1;
      dcyc = -1;
      chk("busy_after_start", {31'b0, busy}, 32'd1);
      while (n < 200) begin
         if (n == abort) begin
            rst_n = 1'b0;
            #1;
            chk("abort_outs_zero", {31'b0, any_out()}, 32'd0);
            chk("abort_busy", {31'b0, busy}, 32'd0);
            break;
         end
         if (done) begin
            dcyc = n;
            break;
         end
         if (n == poke || n == poke + 3) begin
            start = 1'b1;
            mode  = (n == poke);
         end
         @(posedge clk); #1;
         start = 1'b0;
         n++;
      end
      if (abort == 0) begin
         @(posedge clk); #1;
         chk("idle_busy", {31'b0, busy}, 32'd0);
         chk("idle_done", {31'b0, done}, 32'd0);
      end
   endtask

   logic [15:0] wrap_exp [0:6];
   int dc, s_wr, s_rd, s_gw, s_gw6, s_pw, s_dn, s_un;

   task automatic snap();
      s_wr = wr_n; s_rd = rd_n; s_gw = gw_n; s_gw6 = gw6_n;
      s_pw = pw_n; s_dn = done_n; s_un = unstable;
   endtask

   initial begin
      wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001,
                   16'h0002, 16'h0003, 16'h0004};
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; bank = 1'b0;
      base_addr = 16'h0; ld_en = 1'b0; ld_rf = 1'b0; ld_bk = 1'b0;
      ld_addr = 16'h0; ld_data = 16'h0;
      #2;
      chk("reset_outs_zero", {31'b0, any_out()}, 32'd0);
      @(posedge clk); #1;
      chk("reset_hold_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      for (int i = 1; i < 8; i++) begin
         ld(1'b1, 1'b1, 16'(i), 16'h1111 * 16'(i));
         ld(1'b0, 1'b0, 16'h0200 + 16'(i - 1), 16'hA000 + 16'(i));
      end

      // Save, ready tied high.
      wait_cfg = 0; snap();
      run(1'b0, 1'b1, 16'h0100, -10, 0, dc);
      chk("save_done_cycle", dc, 32'd8);
      chk("save_nwrites", wr_n - s_wr, 32'd7);
      chk("save_no_reads", rd_n - s_rd, 32'd0);
      for (int i = 0; i < 7; i++) begin
         chk("save_addr", {16'h0, wla[s_wr + i]}, 32'h0100 + i);
         chk("save_data", {16'h0, wld[s_wr + i]}, 32'h1111 * (i + 1));
      end

      // Restore into bank 0.
      snap();
      run(1'b1, 1'b0, 16'h0200, -10, 0, dc);
      chk("rest_done_cycle", dc, 32'd15);
      chk("rest_gen_writes", gw_n - s_gw, 32'd6);
      chk("rest_pc_writes", pw_n - s_pw, 32'd1);
      chk("rest_r6_via_gen", gw6_n - s_gw6, 32'd0);
      chk("rest_both_strobes", both_w, 32'd0);
      for (int i = 1; i < 8; i++)
         chk("rest_reg", {16'h0, rfm[0][i]}, 32'hA000 + i);

      // Save with three wait states per request.
      wait_cfg = 3; snap();
      run(1'b0, 1'b1, 16'h0300, -10, 0, dc);
      chk("wait_done_cycle", dc, 32'd29);
      chk("wait_nwrites", wr_n - s_wr, 32'd7);
      chk("wait_unstable", unstable - s_un, 32'd0);
      chk("wait_first_addr", {16'h0, wla[s_wr]}, 32'h0300);
      chk("wait_last_addr", {16'h0, wla[s_wr + 6]}, 32'h0306);
      chk("wait_last_data", {16'h0, wld[s_wr + 6]}, 32'h7777);

      // Address wrap.
      wait_cfg = 0; snap();
      run(1'b0, 1'b1, 16'hFFFE, -10, 0, dc);
      chk("wrap_done_cycle", dc, 32'd8);
      for (int i = 0; i < 7; i++)
         chk("wrap_addr", {16'h0, wla[s_wr + i]}, {16'h0, wrap_exp[i]});

      // Spurious starts while busy.
      wait_cfg = 1; snap();
      run(1'b0, 1'b0, 16'h0400, 3, 0, dc);
      chk("ign_done_cycle", dc, 32'd15);
      chk("ign_done_pulses", done_n - s_dn, 32'd1);
      chk("ign_nwrites", wr_n - s_wr, 32'd7);
      chk("ign_no_reads", rd_n - s_rd, 32'd0);
      chk("ign_first_addr", {16'h0, wla[s_wr]}, 32'h0400);
      chk("ign_last_data", {16'h0, wld[s_wr + 6]}, 32'hA007);
      chk("req_both", both_r, 32'd0);

      // Reset during restore of r4, then a clean restore.
      wait_cfg = 0;
      run(1'b1, 1'b1, 16'h0200, -10, 7, dc);
      @(posedge clk); #1;
      chk("post_abort_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      for (int i = 1; i < 8; i++)
         ld(1'b0, 1'b0, 16'h0500 + 16'(i - 1), 16'hC000 + 16'(i));
      snap();
      run(1'b1, 1'b1, 16'h0500, -10, 0, dc);
      chk("rerun_done_cycle", dc, 32'd15);
      chk("rerun_pc_writes", pw_n - s_pw, 32'd1);
      for (int i = 1; i < 8; i++)
         chk("rerun_reg", {16'h0, rfm[1][i]}, 32'hC000 + i);
      chk("final_both_strobes", both_w, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_bank_spill.md
Name: reg_bank_spill

Overview:
- Context save/restore sequencer for the 16-bit core; the counterpart that drives the register file's read and write ports on behalf of the interrupt/task-switch logic.
- Save: streams registers r1..r7 of a selected bank to memory.
- Restore: loads r1..r7 from memory back into the bank. r6 (PC) goes through the dedicated PC write port.
- Sits between the register file, the memory arbiter and the control unit. The control unit stalls the core while busy is high.

Parameters:
FIRST_REG, 1, first register transferred (r0 is hardwired zero, never transferred)
LAST_REG, 7, last register transferred
PC_REG, 6, register restored via the PC write port instead of the general write port
ADDR_W, 16, memory address width

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = save (regfile to mem), 1 = restore (mem to regfile)
bank  in  1  bank to transfer; latched at start
base_addr  in  ADDR_W  memory address of the first register's slot; latched at start
busy  out  1  high from the cycle after start until DONE is left
done  out  1  one-cycle pulse on completion
rf_bank  out  1  latched bank; control unit muxes it onto the register file active_bank while busy
rf_read_num  out  3  register file read select
rf_read_data  in  16  combinational read data for rf_read_num
rf_write_num  out  3  register file write select
rf_write_data  out  16  register file write data
rf_write_en  out  1  general write strobe (also updates condition bits in the register file)
rf_pc_write_data  out  16  PC write data
rf_pc_write_en  out  1  PC write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  16  memory write data
mem_we  out  1  write request, held until mem_ready
mem_re  out  1  read request, held until mem_ready
mem_rdata  in  16  read data; valid in the cycle mem_ready is high
mem_ready  in  1  completes the current request on this rising edge

Behaviour:
- Reset (async, any state): state IDLE, idx=FIRST_REG, all outputs 0, holding register 0. Reset mid-transfer abandons it; a partial memory image or partially restored bank is acceptable.
- States: IDLE, SAVE, RD_REQ, RD_WR, DONE.
- IDLE, start=1:
  - latch bank, base_addr and mode; idx=FIRST_REG.
  - go to SAVE (mode 0) or RD_REQ (mode 1).
  - busy goes high next cycle.
  - start in any other state is ignored.
- Address rule: mem_addr = base_addr + (idx - FIRST_REG), modulo 2^ADDR_W. Base 0xFFFE wraps to 0x0000.
- SAVE:
  - rf_read_num=idx, mem_wdata=rf_read_data, mem_we=1.
  - While mem_ready=0: hold all outputs stable.
  - On mem_ready=1: if idx==LAST_REG go to DONE, else idx+1.
  - Back-to-back ready gives 1 cycle per register.
- RD_REQ:
  - mem_re=1.
  - On mem_ready=1: capture mem_rdata into the holding register, go to RD_WR.
- RD_WR, exactly one cycle:
  - If idx==PC_REG: rf_pc_write_en=1, rf_pc_write_data=hold.
  - Else: rf_write_en=1, rf_write_num=idx, rf_write_data=hold.
  - Then go to DONE if idx==LAST_REG, else idx+1 and back to RD_REQ.
  - Restore takes a minimum of 2 cycles per register.
- Never both strobes: rf_write_en and rf_pc_write_en are never high together.
- Never both requests: mem_we and mem_re are never high together.
- DONE: done=1 for one cycle, busy still 1, then IDLE with busy=0.
- Save latency with mem_ready tied high: start at cycle 0, 7 writes in cycles 1..7, done in cycle 8.
- Condition bits are not saved. After restore they reflect the last general write (r7's value).
- Outputs not in use in the current state are driven 0.

Decomposition:
- Shared package: state encoding, REG_PC=6, REG_ZERO=0, mode constants SAVE=0 and RESTORE=1.
- No sub-module is needed. The address adder is inline.

Test Plan:
- Save, mem_ready tied 1, bank 1 holding r1..r7=0x1111..0x7777, base 0x0100 -> writes 0x1111@0x0100 .. 0x7777@0x0106 on consecutive cycles; done in cycle 8.
- Restore, base 0x0200 holding 0xA001..0xA007 -> rf_write_en for r1..r5 and r7 with matching data; r6 written only via rf_pc_write_en with 0xA006; no cycle with both strobes high.
- Wait states: mem_ready low 3 cycles per request during save -> mem_addr/mem_wdata/mem_we stable throughout; exactly 7 accepted writes.
- Address wrap: base 0xFFFE, save -> addresses 0xFFFE, 0xFFFF, 0x0000 .. 0x0004.
- start pulsed while busy, and start with mode=1 mid-save -> ignored; save completes unchanged; exactly one done pulse.
- rst_n low during the restore of r4 -> same cycle all outputs 0, busy=0; a later start runs a full, correct transfer.
